riscv_biu_arbiter: RTL and testbench
====================================

RISCV_BIU_ARBITER -- requirements
Module: riscv_biu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/data width.
REQ-002 SHALL have parameter TIMEOUT, default 64: max wait cycles for bus_ack/bus_err; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  clock, all state on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port im_req  input  1  instruction-fetch request.
REQ-006 SHALL have port im_adr  input  XLEN  fetch address.
REQ-007 SHALL have port im_q  output  XLEN  fetch read data.
REQ-008 SHALL have ports im_ack, im_err  output  1 each  fetch completion and fetch error.
REQ-009 SHALL have port dm_req  input  1  data request.
REQ-010 SHALL have ports dm_adr, dm_d  input  XLEN each  data address and write data.
REQ-011 SHALL have port dm_we  input  1  data write enable.
REQ-012 SHALL have port dm_size  input  biu_size_t  data access size.
REQ-013 SHALL have port dm_q  output  XLEN  data read data.
REQ-014 SHALL have ports dm_ack, dm_err  output  1 each  data completion and data error.
REQ-015 SHALL have port bus_req  output  1  shared-bus request.
REQ-016 SHALL have ports bus_adr, bus_d  output  XLEN each  shared-bus address and write data.
REQ-017 SHALL have ports bus_we  output  1 and bus_size  output  biu_size_t  shared-bus write enable and size.
REQ-018 SHALL have port bus_q  input  XLEN  shared-bus read data.
REQ-019 SHALL have ports bus_ack, bus_err  input  1 each  shared-bus completion and error.

Function
REQ-020 SHALL implement FSM states IDLE, IM_BUSY, DM_BUSY, with at most one outstanding bus transaction.
REQ-021 SHALL, in IDLE with exactly one request, enter the matching BUSY state next cycle, giving 1 cycle of latency from request to bus_req.
REQ-022 SHALL, in IDLE with both requests asserted, grant the requester not granted last (round-robin via a last_grant register, reset value = IM), so the first tie after reset goes to DM.
REQ-023 SHALL assert bus_req=1 only in IM_BUSY or DM_BUSY.
REQ-024 SHALL drive the bus in IM_BUSY as: bus_adr=im_adr, bus_we=0, bus_size=WORD, bus_d=0.
REQ-025 SHALL drive the bus in DM_BUSY as: bus_adr=dm_adr, bus_d=dm_d, bus_we=dm_we, bus_size=dm_size.
REQ-026 SHALL drive bus outputs to 0 in IDLE.
REQ-027 SHALL have requesters hold req and attributes stable until ack/err; the arbiter does not register them.
REQ-028 SHALL route bus_ack/bus_err combinationally only to the granted requester; the other requester's ack/err stays 0.
REQ-029 SHALL route bus_q to both im_q and dm_q.
REQ-030 SHALL return to IDLE on the cycle after bus_ack or bus_err, and update last_grant to the completed requester.
REQ-031 SHALL treat bus_ack and bus_err asserted together as error: err=1, ack=0.
REQ-032 SHALL count wait cycles in a BUSY state with a counter cleared on state entry; if TIMEOUT>0 and the count reaches TIMEOUT without ack/err, it SHALL pulse err for one cycle to the granted requester, deassert bus_req, and return to IDLE.
REQ-033 SHALL NOT restart a grant while the requester's req is low: a requester dropping req mid-transaction (flush) does not abort the bus cycle, and the completion is still consumed.
REQ-034 SHALL ignore bus_ack/bus_err received in IDLE.

Reset
REQ-035 SHALL, while rstn=0, asynchronously force state=IDLE, last_grant=IM, timeout counter=0, with bus_req, im_ack, im_err, dm_ack, dm_err all 0.
REQ-036 SHALL, on reset mid-transaction, abandon the transaction immediately; a stale bus_ack after reset release is ignored per REQ-034.

Verification
REQ-037 SHALL cover: im_req only, adr=0x200, bus_ack after 3 cycles with bus_q=0x00000013 -> bus_req high 1 cycle after im_req, bus_we=0, im_ack=1 with im_q=0x13, dm_ack=0.
REQ-038 SHALL cover: im_req and dm_req both high from reset, constant acks -> grants alternate DM, IM, DM, IM.
REQ-039 SHALL cover: DM write, adr=0x1000, d=0xDEADBEEF, size=WORD, bus_err=1 -> dm_err=1 for one cycle, FSM back in IDLE next cycle.
REQ-040 SHALL cover: TIMEOUT=4, no ack -> requester err after 4 BUSY cycles, bus_req deasserts.
REQ-041 SHALL cover: rstn low during DM_BUSY, then bus_ack after release -> all acks 0, state IDLE.
REQ-042 SHALL cover: bus_ack and bus_err asserted together -> err=1, ack=0.

Source files
------------

// File: rtl/riscv_biu_arbiter.sv
// Shared-bus arbiter for a RISC-V core: instruction-fetch and data ports
// share one single-outstanding bus, with round-robin on ties and an optional
// wait-cycle timeout.

package riscv_biu_pkg;

  // Access size carried on the data port and the shared bus
  typedef enum logic [1:0] {
    BIU_BYTE = 2'd0,
    BIU_HALF = 2'd1,
    BIU_WORD = 2'd2
  } biu_size_t;

endpackage

module riscv_biu_arbiter
  import riscv_biu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rstn,

  // Instruction-fetch requester
  input  logic            im_req,
  input  logic [XLEN-1:0] im_adr,
  output logic [XLEN-1:0] im_q,
  output logic            im_ack,
  output logic            im_err,

  // Data requester
  input  logic            dm_req,
  input  logic [XLEN-1:0] dm_adr,
  input  logic [XLEN-1:0] dm_d,
  input  logic            dm_we,
  input  biu_size_t       dm_size,
  output logic [XLEN-1:0] dm_q,
  output logic            dm_ack,
  output logic            dm_err,

  // Shared bus
  output logic            bus_req,
  output logic [XLEN-1:0] bus_adr,
  output logic [XLEN-1:0] bus_d,
  output logic            bus_we,
  output biu_size_t       bus_size,
  input  logic [XLEN-1:0] bus_q,
  input  logic            bus_ack,
  input  logic            bus_err
);

  // Counter wide enough to hold TIMEOUT; at least one bit when disabled
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic             TO_EN   = (TIMEOUT != 0);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IM_BUSY = 2'd1;
  localparam logic [1:0] S_DM_BUSY = 2'd2;

  localparam logic GNT_IM = 1'b0;
  localparam logic GNT_DM = 1'b1;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             busy_c;
  logic             timeout_c;
  logic             done_c;

  // Read data is broadcast; only the ack/err qualifies it
  assign im_q = bus_q;
  assign dm_q = bus_q;

  // Completion qualifiers common to both BUSY states
  assign busy_c    = (state_q == S_IM_BUSY) || (state_q == S_DM_BUSY);
  assign timeout_c = busy_c && TO_EN && (cnt_q == CNT_MAX) && !bus_ack && !bus_err;
  assign done_c    = busy_c && (bus_ack || bus_err || timeout_c);

  // State, grant history and wait counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_IM;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state, bus drive and completion routing
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    bus_req      = 1'b0;
    bus_adr      = '0;
    bus_d        = '0;
    bus_we       = 1'b0;
    bus_size     = BIU_BYTE;
    im_ack       = 1'b0;
    im_err       = 1'b0;
    dm_ack       = 1'b0;
    dm_err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Bus responses seen here are stale and dropped
        cnt_d = '0;
        if (im_req && dm_req) begin
          state_d = (last_grant_q == GNT_IM) ? S_DM_BUSY : S_IM_BUSY;
        end else if (im_req) begin
          state_d = S_IM_BUSY;
        end else if (dm_req) begin
          state_d = S_DM_BUSY;
        end
      end

      S_IM_BUSY: begin
        bus_req  = !timeout_c;
        bus_adr  = im_adr;
        bus_size = BIU_WORD;
        // Error wins when the slave raises ack and err together
        im_ack   = bus_ack && !bus_err;
        im_err   = bus_err || timeout_c;
        if (done_c) begin
          state_d      = S_IDLE;
          last_grant_d = GNT_IM;
          cnt_d        = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DM_BUSY: begin
        bus_req  = !timeout_c;
        bus_adr  = dm_adr;
        bus_d    = dm_d;
        bus_we   = dm_we;
        bus_size = dm_size;
        dm_ack   = bus_ack && !bus_err;
        dm_err   = bus_err || timeout_c;
        if (done_c) begin
          state_d      = S_IDLE;
          last_grant_d = GNT_DM;
          cnt_d        = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// Directed bench for riscv_biu_arbiter (TIMEOUT=4 so the timeout is reachable).

module tb_riscv_biu_arbiter;
  import riscv_biu_pkg::*;

  logic        clk;
  logic        rstn;
  logic        im_req;
  logic [31:0] im_adr;
  logic [31:0] im_q;
  logic        im_ack;
  logic        im_err;
  logic        dm_req;
  logic [31:0] dm_adr;
  logic [31:0] dm_d;
  logic        dm_we;
  biu_size_t   dm_size;
  logic [31:0] dm_q;
  logic        dm_ack;
  logic        dm_err;
  logic        bus_req;
  logic [31:0] bus_adr;
  logic [31:0] bus_d;
  logic        bus_we;
  biu_size_t   bus_size;
  logic [31:0] bus_q;
  logic        bus_ack;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  rr_exp [8];
  logic [31:0] rr_adr [8];

  riscv_biu_arbiter #(
    .XLEN    (32),
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .im_req   (im_req),
    .im_adr   (im_adr),
    .im_q     (im_q),
    .im_ack   (im_ack),
    .im_err   (im_err),
    .dm_req   (dm_req),
    .dm_adr   (dm_adr),
    .dm_d     (dm_d),
    .dm_we    (dm_we),
    .dm_size  (dm_size),
    .dm_q     (dm_q),
    .dm_ack   (dm_ack),
    .dm_err   (dm_err),
    .bus_req  (bus_req),
    .bus_adr  (bus_adr),
    .bus_d    (bus_d),
    .bus_we   (bus_we),
    .bus_size (bus_size),
    .bus_q    (bus_q),
    .bus_ack  (bus_ack),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge before driving inputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn    = 1'b0;
    im_req  = 1'b0;
    im_adr  = '0;
    dm_req  = 1'b0;
    dm_adr  = '0;
    dm_d    = '0;
    dm_we   = 1'b0;
    dm_size = BIU_BYTE;
    bus_q   = '0;
    bus_ack = 1'b0;
    bus_err = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_bus_req", 64'(bus_req), 64'h0);
    check_eq("rst_acks", 64'({im_ack, im_err, dm_ack, dm_err}), 64'h0);
    check_eq("rst_bus_adr", 64'(bus_adr), 64'h0);
    rstn = 1'b1;

    // Fetch only, ack on third BUSY cycle
    tick(); im_req = 1'b1; im_adr = 32'h200;
    @(negedge clk); check_eq("a_latency", 64'(bus_req), 64'h0);
    tick(); @(negedge clk);
    check_eq("a_bus_req", 64'(bus_req), 64'h1);
    check_eq("a_bus_adr", 64'(bus_adr), 64'h200);
    check_eq("a_bus_we", 64'(bus_we), 64'h0);
    check_eq("a_bus_size", 64'(bus_size), 64'h2);
    check_eq("a_bus_d", 64'(bus_d), 64'h0);
    tick(); @(negedge clk); check_eq("a_wait_ack", 64'(im_ack), 64'h0);
    tick(); bus_ack = 1'b1; bus_q = 32'h0000_0013;
    @(negedge clk);
    check_eq("a_im_ack", 64'(im_ack), 64'h1);
    check_eq("a_im_q", 64'(im_q), 64'h13);
    check_eq("a_dm_q", 64'(dm_q), 64'h13);
    check_eq("a_dm_ack", 64'(dm_ack), 64'h0);
    check_eq("a_im_err", 64'(im_err), 64'h0);
    tick(); bus_ack = 1'b0; im_req = 1'b0;
    @(negedge clk);
    check_eq("a_idle", 64'(bus_req), 64'h0);
    check_eq("a_ack_pulse", 64'(im_ack), 64'h0);

    // Fetch flushed mid-transaction still completes, no regrant
    tick(); im_req = 1'b1; im_adr = 32'h240;
    tick(); @(negedge clk); check_eq("f_busy", 64'(bus_req), 64'h1);
    tick(); im_req = 1'b0;
    @(negedge clk);
    check_eq("f_hold_req", 64'(bus_req), 64'h1);
    check_eq("f_hold_adr", 64'(bus_adr), 64'h240);
    tick(); bus_ack = 1'b1;
    @(negedge clk); check_eq("f_im_ack", 64'(im_ack), 64'h1);
    tick(); bus_ack = 1'b0;
    @(negedge clk); check_eq("f_idle", 64'(bus_req), 64'h0);
    tick(); @(negedge clk); check_eq("f_no_regrant", 64'(bus_req), 64'h0);

    // Simultaneous ack and err reported as error
    tick(); im_req = 1'b1; im_adr = 32'h300;
    tick(); bus_ack = 1'b1; bus_err = 1'b1;
    @(negedge clk);
    check_eq("c_im_err", 64'(im_err), 64'h1);
    check_eq("c_im_ack", 64'(im_ack), 64'h0);
    check_eq("c_dm_err", 64'(dm_err), 64'h0);
    tick(); bus_ack = 1'b0; bus_err = 1'b0; im_req = 1'b0;
    @(negedge clk);
    check_eq("c_idle", 64'(bus_req), 64'h0);
    check_eq("c_err_pulse", 64'(im_err), 64'h0);

    // Data write answered with bus error
    tick(); dm_req = 1'b1; dm_adr = 32'h1000; dm_d = 32'hDEAD_BEEF; dm_we = 1'b1; dm_size = BIU_WORD;
    tick(); @(negedge clk);
    check_eq("b_bus_req", 64'(bus_req), 64'h1);
    check_eq("b_bus_adr", 64'(bus_adr), 64'h1000);
    check_eq("b_bus_d", 64'(bus_d), 64'hDEAD_BEEF);
    check_eq("b_bus_we", 64'(bus_we), 64'h1);
    check_eq("b_bus_size", 64'(bus_size), 64'h2);
    check_eq("b_im_ack", 64'(im_ack), 64'h0);
    tick(); bus_err = 1'b1;
    @(negedge clk);
    check_eq("b_dm_err", 64'(dm_err), 64'h1);
    check_eq("b_dm_ack", 64'(dm_ack), 64'h0);
    check_eq("b_im_err", 64'(im_err), 64'h0);
    tick(); bus_err = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    check_eq("b_idle", 64'(bus_req), 64'h0);
    check_eq("b_err_pulse", 64'(dm_err), 64'h0);
    check_eq("b_idle_adr", 64'(bus_adr), 64'h0);

    // Data read with no response times out after 4 BUSY cycles
    tick(); dm_req = 1'b1; dm_adr = 32'h2000; dm_size = BIU_HALF;
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      check_eq($sformatf("d_wait_req%0d", i), 64'(bus_req), 64'h1);
      check_eq($sformatf("d_wait_err%0d", i), 64'(dm_err), 64'h0);
    end
    check_eq("d_bus_size", 64'(bus_size), 64'h1);
    tick(); @(negedge clk);
    check_eq("d_to_err", 64'(dm_err), 64'h1);
    check_eq("d_to_req", 64'(bus_req), 64'h0);
    check_eq("d_to_ack", 64'(dm_ack), 64'h0);
    tick(); dm_req = 1'b0;
    @(negedge clk);
    check_eq("d_idle", 64'(bus_req), 64'h0);
    check_eq("d_err_pulse", 64'(dm_err), 64'h0);

    // Reset during DM_BUSY, stale ack afterwards ignored
    tick(); dm_req = 1'b1; dm_adr = 32'h3000;
    tick(); @(negedge clk); check_eq("r_busy", 64'(bus_req), 64'h1);
    rstn = 1'b0; dm_req = 1'b0;
    #1;
    check_eq("r_abort_req", 64'(bus_req), 64'h0);
    check_eq("r_abort_acks", 64'({im_ack, im_err, dm_ack, dm_err}), 64'h0);
    @(negedge clk); rstn = 1'b1;
    tick(); bus_ack = 1'b1;
    @(negedge clk);
    check_eq("r_stale_acks", 64'({im_ack, im_err, dm_ack, dm_err}), 64'h0);
    check_eq("r_stale_req", 64'(bus_req), 64'h0);
    tick(); bus_ack = 1'b0;

    // Both requesting from reset with constant ack: DM, IM, DM, IM
    rr_exp = '{3'b110, 3'b000, 3'b101, 3'b000, 3'b110, 3'b000, 3'b101, 3'b000};
    rr_adr = '{32'h222, 32'h0, 32'h111, 32'h0, 32'h222, 32'h0, 32'h111, 32'h0};
    rstn   = 1'b0;
    im_adr = 32'h111; dm_adr = 32'h222; dm_we = 1'b0; dm_size = BIU_WORD;
    im_req = 1'b1; dm_req = 1'b1; bus_ack = 1'b1; bus_q = 32'h55;
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("rr_grant%0d", i), 64'({bus_req, dm_ack, im_ack}), 64'(rr_exp[i]));
      check_eq($sformatf("rr_adr%0d", i), 64'(bus_adr), 64'(rr_adr[i]));
    end
    tick(); im_req = 1'b0; dm_req = 1'b0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
